// File: rtl/letc_core_mem_arbiter.sv
// Purpose: shares the single LETC Core memory port between fetch and data; data has priority.
// Latency: grant -> bus request next cycle -> response pulse the cycle after bus response (min 3).
// Backpressure: ready only in IDLE, one outstanding; bus fields held until i_bus_req_ready. Macro LETC_CORE_MEM_ARBITER_STARVE_GUARD_EN adds a fetch starvation guard.

package letc_pkg;
    typedef logic [33:0] paddr_t;
endpackage

package letc_core_pkg;
    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'd0,
        SIZE_HALFWORD = 2'd1,
        SIZE_WORD     = 2'd2
    } size_e;
endpackage

module letc_core_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_f_req_valid,
    output logic             o_f_req_ready,
    input  letc_pkg::paddr_t i_f_addr,
    input  logic             i_f_flush,
    output logic             o_f_rsp_valid,
    output logic [31:0]      o_f_rsp_rdata,
    input  logic             i_d_req_valid,
    output logic             o_d_req_ready,
    input  letc_pkg::paddr_t i_d_addr,
    input  logic             i_d_we,
    input  logic [31:0]      i_d_wdata,
    input  logic [1:0]       i_d_size,
    output logic             o_d_rsp_valid,
    output logic [31:0]      o_d_rsp_rdata,
    output logic             o_bus_req_valid,
    input  logic             i_bus_req_ready,
    output letc_pkg::paddr_t o_bus_addr,
    output logic             o_bus_we,
    output logic [31:0]      o_bus_wdata,
    output logic [1:0]       o_bus_size,
    input  logic             i_bus_rsp_valid,
    input  logic [31:0]      i_bus_rsp_rdata
);
    import letc_core_pkg::*;

    typedef struct packed {
        letc_pkg::paddr_t addr;
        logic             we;
        logic [31:0]      wdata;
        logic [1:0]       size;
    } bus_req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
    typedef enum logic {OWNER_DATA, OWNER_FETCH} owner_e;

    state_e   state_q;
    owner_e   owner_q;
    logic     drop_q;
    bus_req_t bus_q;
    logic     idle;
    logic     f_ok;
    logic     f_win;
    logic     d_win;
    logic     starve_hit;

    assign o_bus_addr  = bus_q.addr;
    assign o_bus_we    = bus_q.we;
    assign o_bus_wdata = bus_q.wdata;
    assign o_bus_size  = bus_q.size;

`ifdef LETC_CORE_MEM_ARBITER_STARVE_GUARD_EN
    logic [3:0] starve_q;

    assign starve_hit = (starve_q >= 4'(STARVE_LIMIT));

    // Counts data grants that left a live fetch waiting; saturates at 15.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            starve_q <= '0;
        end else if (o_f_req_ready) begin
            starve_q <= '0;
        end else if (o_d_req_ready && f_ok && (starve_q != 4'hF)) begin
            starve_q <= starve_q + 4'd1;
        end
    end
`else
    logic unused_starve_limit;

    assign unused_starve_limit = (STARVE_LIMIT != 0);
    assign starve_hit          = 1'b0;
`endif

    // Ready is held low during reset so every output reads 0 while i_rst is high.
    always_comb begin
        idle  = (state_q == IDLE) && !i_rst;
        f_ok  = i_f_req_valid && !i_f_flush;
        f_win = f_ok && (!i_d_req_valid || starve_hit);
        d_win = i_d_req_valid && !f_win;
    end

    assign o_f_req_ready = idle && f_win;
    assign o_d_req_ready = idle && d_win;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q         <= IDLE;
            owner_q         <= OWNER_DATA;
            drop_q          <= 1'b0;
            bus_q           <= '0;
            o_bus_req_valid <= 1'b0;
            o_f_rsp_valid   <= 1'b0;
            o_d_rsp_valid   <= 1'b0;
            o_f_rsp_rdata   <= '0;
            o_d_rsp_rdata   <= '0;
        end else begin
            o_f_rsp_valid <= 1'b0;
            o_d_rsp_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (o_d_req_ready) begin
                        bus_q   <= '{addr: i_d_addr, we: i_d_we, wdata: i_d_wdata, size: i_d_size};
                        owner_q <= OWNER_DATA;
                    end else if (o_f_req_ready) begin
                        bus_q   <= '{addr: i_f_addr, we: 1'b0, wdata: 32'd0, size: SIZE_WORD};
                        owner_q <= OWNER_FETCH;
                    end
                    if (o_d_req_ready || o_f_req_ready) begin
                        o_bus_req_valid <= 1'b1;
                        drop_q          <= 1'b0;
                        state_q         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if ((owner_q == OWNER_FETCH) && i_f_flush) begin
                        drop_q <= 1'b1;
                    end
                    if (i_bus_req_ready) begin
                        o_bus_req_valid <= 1'b0;
                        state_q         <= WAIT;
                    end
                end
                WAIT: begin
                    if ((owner_q == OWNER_FETCH) && i_f_flush) begin
                        drop_q <= 1'b1;
                    end
                    if (i_bus_rsp_valid) begin
                        state_q <= IDLE;
                        drop_q  <= 1'b0;
                        if (owner_q == OWNER_DATA) begin
                            o_d_rsp_valid <= 1'b1;
                            o_d_rsp_rdata <= bus_q.we ? 32'd0 : i_bus_rsp_rdata;
                        end else if (!drop_q && !i_f_flush) begin
                            // A flush landing on the response cycle still discards it.
                            o_f_rsp_valid <= 1'b1;
                            o_f_rsp_rdata <= i_bus_rsp_rdata;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_letc_core_mem_arbiter.sv
// Bench for letc_core_mem_arbiter: vector table, directed corner sequences, randomized run vs transaction model.
module tb_letc_core_mem_arbiter;

`ifdef LETC_CORE_MEM_ARBITER_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int LIMIT = 4;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_f_req_valid;
    logic             o_f_req_ready;
    letc_pkg::paddr_t i_f_addr;
    logic             i_f_flush;
    logic             o_f_rsp_valid;
    logic [31:0]      o_f_rsp_rdata;
    logic             i_d_req_valid;
    logic             o_d_req_ready;
    letc_pkg::paddr_t i_d_addr;
    logic             i_d_we;
    logic [31:0]      i_d_wdata;
    logic [1:0]       i_d_size;
    logic             o_d_rsp_valid;
    logic [31:0]      o_d_rsp_rdata;
    logic             o_bus_req_valid;
    logic             i_bus_req_ready;
    letc_pkg::paddr_t o_bus_addr;
    logic             o_bus_we;
    logic [31:0]      o_bus_wdata;
    logic [1:0]       o_bus_size;
    logic             i_bus_rsp_valid;
    logic [31:0]      i_bus_rsp_rdata;

    letc_core_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_f_req_valid(i_f_req_valid), .o_f_req_ready(o_f_req_ready), .i_f_addr(i_f_addr),
        .i_f_flush(i_f_flush), .o_f_rsp_valid(o_f_rsp_valid), .o_f_rsp_rdata(o_f_rsp_rdata),
        .i_d_req_valid(i_d_req_valid), .o_d_req_ready(o_d_req_ready), .i_d_addr(i_d_addr),
        .i_d_we(i_d_we), .i_d_wdata(i_d_wdata), .i_d_size(i_d_size),
        .o_d_rsp_valid(o_d_rsp_valid), .o_d_rsp_rdata(o_d_rsp_rdata),
        .o_bus_req_valid(o_bus_req_valid), .i_bus_req_ready(i_bus_req_ready),
        .o_bus_addr(o_bus_addr), .o_bus_we(o_bus_we), .o_bus_wdata(o_bus_wdata),
        .o_bus_size(o_bus_size), .i_bus_rsp_valid(i_bus_rsp_valid), .i_bus_rsp_rdata(i_bus_rsp_rdata)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic fv;
        logic ff;
        logic dv;
        logic ef;
        logic ed;
    } vec_t;

    vec_t vecs[7];
    int   n_checks = 0;
    int   n_errors = 0;

    // Transaction-level reference model state
    bit               pend, issued, drop, p_fetch, exp_fp, exp_dp;
    letc_pkg::paddr_t p_addr;
    logic             p_we;
    logic [31:0]      p_wdata, last_f, last_d;
    logic [1:0]       p_size;
    int               starve;
    bit               m_fok, m_fwin, m_dwin;
    int               ngrant;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic clear_inputs();
        i_f_req_valid = 1'b0; i_f_addr = '0; i_f_flush = 1'b0;
        i_d_req_valid = 1'b0; i_d_addr = '0; i_d_we = 1'b0; i_d_wdata = '0; i_d_size = '0;
        i_bus_req_ready = 1'b0; i_bus_rsp_valid = 1'b0; i_bus_rsp_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        clear_inputs();
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            fv    ff    dv    ef    ed
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        i_rst = 1'b1;
        clear_inputs();
        @(negedge i_clk); #1;
        chk("rst_f_rdy", o_f_req_ready, 0);
        chk("rst_d_rdy", o_d_req_ready, 0);
        chk("rst_f_rsp", o_f_rsp_valid, 0);
        chk("rst_d_rsp", o_d_rsp_valid, 0);
        chk("rst_bus_vld", o_bus_req_valid, 0);
        chk("rst_bus_fields", {o_bus_addr, o_bus_we, o_bus_size}, 0);
        chk("rst_rdata", {o_f_rsp_rdata, o_d_rsp_rdata}, 0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Combinational arbitration in IDLE; valids drop before the edge so no grant happens
        for (int i = 0; i < 7; i++) begin
            @(negedge i_clk);
            i_f_req_valid = vecs[i].fv; i_f_flush = vecs[i].ff; i_d_req_valid = vecs[i].dv;
            #1;
            chk($sformatf("vec%0d_f_rdy", i), o_f_req_ready, vecs[i].ef);
            chk($sformatf("vec%0d_d_rdy", i), o_d_req_ready, vecs[i].ed);
            i_f_req_valid = 1'b0; i_f_flush = 1'b0; i_d_req_valid = 1'b0;
        end

        // Lone fetch, minimum latency
        @(negedge i_clk);
        i_f_req_valid = 1'b1; i_f_addr = 34'h1000;
        #1 chk("lone_f_rdy", o_f_req_ready, 1);
        @(negedge i_clk);
        i_f_req_valid = 1'b0; i_bus_req_ready = 1'b1;
        #1 chk("lone_bus_vld", o_bus_req_valid, 1);
        chk("lone_bus_addr", o_bus_addr, 34'h1000);
        chk("lone_bus_size", o_bus_size, 2);
        chk("lone_bus_we", o_bus_we, 0);
        @(negedge i_clk);
        i_bus_req_ready = 1'b0; i_bus_rsp_valid = 1'b1; i_bus_rsp_rdata = 32'hDEADBEEF;
        #1 chk("lone_bus_vld_wait", o_bus_req_valid, 0);
        chk("lone_f_rsp_early", o_f_rsp_valid, 0);
        @(negedge i_clk);
        i_bus_rsp_valid = 1'b0;
        #1 chk("lone_f_rsp_vld", o_f_rsp_valid, 1);
        chk("lone_f_rsp_rdata", o_f_rsp_rdata, 32'hDEADBEEF);
        chk("lone_d_rsp_vld", o_d_rsp_valid, 0);
        @(negedge i_clk); #1;
        chk("lone_f_rsp_pulse", o_f_rsp_valid, 0);
        chk("lone_f_rdata_hold", o_f_rsp_rdata, 32'hDEADBEEF);

        // Simultaneous fetch and data store
        @(negedge i_clk);
        i_f_req_valid = 1'b1; i_f_addr = 34'h1004;
        i_d_req_valid = 1'b1; i_d_addr = 34'h2000; i_d_we = 1'b1; i_d_wdata = 32'h55; i_d_size = 2'd0;
        #1 chk("pri_d_rdy", o_d_req_ready, 1);
        chk("pri_f_rdy", o_f_req_ready, 0);
        @(negedge i_clk);
        i_d_req_valid = 1'b0; i_bus_req_ready = 1'b1;
        #1 chk("pri_bus_we", o_bus_we, 1);
        chk("pri_bus_size", o_bus_size, 0);
        chk("pri_bus_addr", o_bus_addr, 34'h2000);
        chk("pri_bus_wdata", o_bus_wdata, 32'h55);
        chk("pri_f_rdy_issue", o_f_req_ready, 0);
        @(negedge i_clk);
        i_bus_req_ready = 1'b0; i_bus_rsp_valid = 1'b1; i_bus_rsp_rdata = 32'h12345678;
        #1 chk("pri_f_rdy_wait", o_f_req_ready, 0);
        @(negedge i_clk);
        i_bus_rsp_valid = 1'b0;
        #1 chk("pri_d_rsp_vld", o_d_rsp_valid, 1);
        chk("pri_d_rsp_rdata", o_d_rsp_rdata, 0);
        chk("pri_f_rdy_idle", o_f_req_ready, 1);
        @(negedge i_clk);
        i_f_req_valid = 1'b0; i_bus_req_ready = 1'b1;
        #1 chk("pri_f_bus_addr", o_bus_addr, 34'h1004);
        chk("pri_f_bus_we_wdata", {o_bus_we, o_bus_wdata}, 0);
        @(negedge i_clk);
        i_bus_req_ready = 1'b0; i_bus_rsp_valid = 1'b1; i_bus_rsp_rdata = 32'hCAFEF00D;
        @(negedge i_clk);
        i_bus_rsp_valid = 1'b0;
        #1 chk("pri_f_rsp_vld", o_f_rsp_valid, 1);
        chk("pri_f_rsp_rdata", o_f_rsp_rdata, 32'hCAFEF00D);

        // Bus ready withheld for 5 cycles; requester inputs change underneath
        @(negedge i_clk);
        i_d_req_valid = 1'b1; i_d_addr = 34'h3_0000_0040; i_d_we = 1'b0; i_d_wdata = 32'h77; i_d_size = 2'd1;
        i_f_req_valid = 1'b1; i_f_addr = 34'h1008;
        #1 chk("stall_d_rdy", o_d_req_ready, 1);
        @(negedge i_clk);
        i_d_addr = '0; i_d_wdata = 32'hFFFF_FFFF; i_d_size = 2'd2;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("stall%0d_bus_vld", k), o_bus_req_valid, 1);
            chk($sformatf("stall%0d_bus_fields", k), {o_bus_addr, o_bus_we, o_bus_size}, {34'h3_0000_0040, 1'b0, 2'd1});
            chk($sformatf("stall%0d_bus_wdata", k), o_bus_wdata, 32'h77);
            chk($sformatf("stall%0d_rdys", k), {o_f_req_ready, o_d_req_ready}, 0);
            @(negedge i_clk);
        end
        i_bus_req_ready = 1'b1; i_f_req_valid = 1'b0; i_d_req_valid = 1'b0;
        #1 chk("stall_bus_vld_end", o_bus_req_valid, 1);
        @(negedge i_clk);
        i_bus_req_ready = 1'b0; i_bus_rsp_valid = 1'b1; i_bus_rsp_rdata = 32'h0BADF00D;
        @(negedge i_clk);
        i_bus_rsp_valid = 1'b0;
        #1 chk("stall_d_rsp_vld", o_d_rsp_valid, 1);
        chk("stall_d_rsp_rdata", o_d_rsp_rdata, 32'h0BADF00D);
        chk("stall_f_rsp_vld", o_f_rsp_valid, 0);

        // Flush during WAIT drops the response; the next fetch is delivered
        @(negedge i_clk);
        i_f_req_valid = 1'b1; i_f_addr = 34'h100C;
        #1 chk("fl_f_rdy", o_f_req_ready, 1);
        @(negedge i_clk);
        i_f_req_valid = 1'b0; i_bus_req_ready = 1'b1;
        @(negedge i_clk);
        i_bus_req_ready = 1'b0; i_f_flush = 1'b1;
        #1 chk("fl_bus_vld_wait", o_bus_req_valid, 0);
        @(negedge i_clk);
        i_f_flush = 1'b0; i_bus_rsp_valid = 1'b1; i_bus_rsp_rdata = 32'h11111111;
        @(negedge i_clk);
        i_bus_rsp_valid = 1'b0;
        #1 chk("fl_f_rsp_dropped", o_f_rsp_valid, 0);
        chk("fl_f_rdata_hold", o_f_rsp_rdata, 32'hCAFEF00D);
        i_f_req_valid = 1'b1; i_f_addr = 34'h1010;
        #1 chk("fl2_f_rdy", o_f_req_ready, 1);
        @(negedge i_clk);
        i_f_req_valid = 1'b0; i_bus_req_ready = 1'b1;
        #1 chk("fl2_bus_addr", o_bus_addr, 34'h1010);
        @(negedge i_clk);
        i_bus_req_ready = 1'b0; i_bus_rsp_valid = 1'b1; i_bus_rsp_rdata = 32'hA5A5F00D;
        @(negedge i_clk);
        i_bus_rsp_valid = 1'b0;
        #1 chk("fl2_f_rsp_vld", o_f_rsp_valid, 1);
        chk("fl2_f_rsp_rdata", o_f_rsp_rdata, 32'hA5A5F00D);

        // Asynchronous reset while in WAIT
        @(negedge i_clk);
        i_d_req_valid = 1'b1; i_d_addr = 34'h4000; i_d_we = 1'b0; i_d_size = 2'd2;
        #1 chk("rstw_d_rdy", o_d_req_ready, 1);
        @(negedge i_clk);
        i_bus_req_ready = 1'b1; i_f_req_valid = 1'b1;
        @(negedge i_clk);
        i_bus_req_ready = 1'b0;
        i_rst = 1'b1;
        #1 chk("rstw_bus_addr", o_bus_addr, 0);
        chk("rstw_bus_size", o_bus_size, 0);
        chk("rstw_rdys", {o_f_req_ready, o_d_req_ready}, 0);
        chk("rstw_f_rdata", o_f_rsp_rdata, 0);
        chk("rstw_d_rdata", o_d_rsp_rdata, 0);
        chk("rstw_bus_vld", o_bus_req_valid, 0);
        i_d_req_valid = 1'b0; i_f_req_valid = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk); #1;
        chk("rstw_no_stale_rsp", {o_f_rsp_valid, o_d_rsp_valid}, 0);
        i_d_req_valid = 1'b1;
        #1 chk("rstw_idle_d_rdy", o_d_req_ready, 1);
        i_d_req_valid = 1'b0;

        // Both requesters permanently valid; bus always ready and responding
        do_reset();
        i_f_req_valid = 1'b1; i_f_addr = 34'h2222; i_d_req_valid = 1'b1; i_d_addr = 34'h3333;
        i_bus_req_ready = 1'b1; i_bus_rsp_valid = 1'b1; i_bus_rsp_rdata = 32'h5A5A;
        ngrant = 0;
        for (int c = 0; c < 200 && ngrant < 10; c++) begin
            @(negedge i_clk); #1;
            if (o_f_req_ready || o_d_req_ready) begin
                chk($sformatf("fair_grant%0d_is_fetch", ngrant), o_f_req_ready, GUARD && (ngrant % 5 == 4));
                ngrant++;
            end
        end
        chk("fair_grant_count", ngrant, 10);

        // Randomized run against the transaction model
        do_reset();
        pend = 0; issued = 0; drop = 0; exp_fp = 0; exp_dp = 0;
        last_f = '0; last_d = '0; starve = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge i_clk);
            i_f_req_valid   = ($urandom_range(0, 2) != 0);
            i_f_flush       = ($urandom_range(0, 9) == 0);
            i_f_addr        = {2'($urandom_range(0, 3)), 32'($urandom)};
            i_d_req_valid   = ($urandom_range(0, 2) == 0);
            i_d_addr        = {2'($urandom_range(0, 3)), 32'($urandom)};
            i_d_we          = 1'($urandom_range(0, 1));
            i_d_wdata       = $urandom;
            i_d_size        = 2'($urandom_range(0, 2));
            i_bus_req_ready = 1'($urandom_range(0, 1));
            i_bus_rsp_valid = ($urandom_range(0, 2) == 0);
            i_bus_rsp_rdata = $urandom;
            #1;
            chk("rnd_f_rsp_vld", o_f_rsp_valid, exp_fp);
            chk("rnd_d_rsp_vld", o_d_rsp_valid, exp_dp);
            chk("rnd_f_rdata", o_f_rsp_rdata, last_f);
            chk("rnd_d_rdata", o_d_rsp_rdata, last_d);
            chk("rnd_bus_vld", o_bus_req_valid, pend && !issued);
            if (pend) begin
                chk("rnd_bus_addr", o_bus_addr, p_addr);
                chk("rnd_bus_ctl", {o_bus_we, o_bus_size, o_bus_wdata}, {p_we, p_size, p_wdata});
            end
            m_fok  = i_f_req_valid && !i_f_flush;
            m_fwin = m_fok && (!i_d_req_valid || (GUARD && starve >= LIMIT));
            m_dwin = i_d_req_valid && !m_fwin;
            chk("rnd_f_rdy", o_f_req_ready, !pend && m_fwin);
            chk("rnd_d_rdy", o_d_req_ready, !pend && m_dwin);

            exp_fp = 0; exp_dp = 0;
            if (pend) begin
                if (p_fetch && i_f_flush) drop = 1;
                if (!issued) begin
                    if (i_bus_req_ready) issued = 1;
                end else if (i_bus_rsp_valid) begin
                    if (!p_fetch) begin
                        exp_dp = 1;
                        last_d = p_we ? 32'd0 : i_bus_rsp_rdata;
                    end else if (!drop) begin
                        exp_fp = 1;
                        last_f = i_bus_rsp_rdata;
                    end
                    pend = 0;
                end
            end else if (m_fwin || m_dwin) begin
                pend = 1; issued = 0; drop = 0; p_fetch = m_fwin;
                if (m_fwin) begin
                    p_addr = i_f_addr; p_we = 0; p_wdata = 0; p_size = 2'd2;
                    starve = 0;
                end else begin
                    p_addr = i_d_addr; p_we = i_d_we; p_wdata = i_d_wdata; p_size = i_d_size;
                    if (m_fok && starve < 15) starve++;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
